i3c_cmd_sequencer: RTL

Command-queue and dispatch stage directly upstream of i3c_controller. Buffers host transfer commands (address, direction, write byte) in a small FIFO and launches them one at a time on the controller's start_transfer/device_address/is_read/write_data interface. Collects read_data, transfer_complete and error back. Retries errored transfers, enforces a completion timeout, and returns one status/response per command over a valid/ready channel.

---
 rtl/i3c_cmd_sequencer_if.sv | 28 ++
 rtl/i3c_cmd_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/i3c_cmd_sequencer_if.sv
// Host-side command and response channels of the I3C command sequencer.
// Member names carry the sequencer's own port direction suffixes.
interface i3c_cmd_sequencer_if #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8
);
    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    logic [ADDR_WIDTH-1:0] cmd_addr_i;
    logic                  cmd_rnw_i;
    logic [DATA_WIDTH-1:0] cmd_wdata_i;
    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [ADDR_WIDTH-1:0] rsp_addr_o;
    logic [DATA_WIDTH-1:0] rsp_rdata_o;
    logic [1:0]            rsp_status_o;
    logic [1:0]            rsp_retries_o;

    modport master (
        output cmd_valid_i, cmd_addr_i, cmd_rnw_i, cmd_wdata_i, rsp_ready_i,
        input  cmd_ready_o, rsp_valid_o, rsp_addr_o, rsp_rdata_o, rsp_status_o, rsp_retries_o
    );

    modport slave (
        input  cmd_valid_i, cmd_addr_i, cmd_rnw_i, cmd_wdata_i, rsp_ready_i,
        output cmd_ready_o, rsp_valid_o, rsp_addr_o, rsp_rdata_o, rsp_status_o, rsp_retries_o
    );
endinterface

// File: rtl/i3c_cmd_sequencer.sv
// Command FIFO and single-outstanding dispatch stage in front of i3c_controller,
// with error retry, completion timeout and one response per command.
module i3c_cmd_sequencer #(
    parameter int ADDR_WIDTH     = 7,
    parameter int DATA_WIDTH     = 8,
    parameter int STATE_WIDTH    = 3,
    parameter int IDLE_CODE      = 0,
    parameter int CMD_DEPTH      = 4,
    parameter int MAX_RETRY      = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    i3c_cmd_sequencer_if.slave           host_if,
    output logic [ADDR_WIDTH-1:0]        ctrl_device_address_o,
    output logic                         ctrl_is_read_o,
    output logic [DATA_WIDTH-1:0]        ctrl_write_data_o,
    output logic                         ctrl_start_transfer_o,
    input  logic [DATA_WIDTH-1:0]        ctrl_read_data_i,
    input  logic                         ctrl_transfer_complete_i,
    input  logic                         ctrl_error_i,
    input  logic [STATE_WIDTH-1:0]       ctrl_state_i,
    output logic [$clog2(CMD_DEPTH):0]   fifo_level_o,
    output logic                         busy_o
);
    // state    | meaning
    // S_IDLE   | wait for a queued command and an idle controller
    // S_LAUNCH | one-cycle start pulse to the controller
    // S_WAIT   | wait for complete/error, timeout counter running
    // S_RESP   | response presented until the host accepts it
    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_e;

    localparam int PTR_W = $clog2(CMD_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int RTY_W = ($clog2(MAX_RETRY + 1) > 2) ? $clog2(MAX_RETRY + 1) : 2;

    localparam logic [STATE_WIDTH-1:0] CTRL_IDLE = STATE_WIDTH'(IDLE_CODE);
    localparam logic [LVL_W-1:0]       LVL_FULL  = LVL_W'(CMD_DEPTH);
    localparam logic [TMR_W-1:0]       TMR_LOAD  = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RTY_W-1:0]       RTY_MAX   = RTY_W'(MAX_RETRY);

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_ERROR   = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    state_e                  state_q, state_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]        level_q, level_d;
    logic                    ready_en_q;
    logic [TMR_W-1:0]        timer_q, timer_d;
    logic [RTY_W-1:0]        retry_q, retry_d;
    logic [ADDR_WIDTH-1:0]   ctrl_addr_q, ctrl_addr_d;
    logic                    ctrl_rnw_q, ctrl_rnw_d;
    logic [DATA_WIDTH-1:0]   ctrl_wdata_q, ctrl_wdata_d;
    logic [ADDR_WIDTH-1:0]   rsp_addr_q, rsp_addr_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]              rsp_status_q, rsp_status_d;
    logic [1:0]              rsp_retries_q, rsp_retries_d;

    logic [ADDR_WIDTH-1:0]   fifo_addr_q  [CMD_DEPTH];
    logic                    fifo_rnw_q   [CMD_DEPTH];
    logic [DATA_WIDTH-1:0]   fifo_wdata_q [CMD_DEPTH];

    logic cmd_ready;
    logic push;
    logic pop;

    assign cmd_ready = ready_en_q && (level_q != LVL_FULL);
    assign push      = host_if.cmd_valid_i && cmd_ready;
    assign pop       = (state_q == S_RESP) && host_if.rsp_ready_i;

    function automatic logic [1:0] sat_retries(input logic [RTY_W-1:0] r);
        return (r > RTY_W'(3)) ? 2'd3 : r[1:0];
    endfunction

    // Storage carries no reset; validity is tracked by the pointers and level.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q]  <= host_if.cmd_addr_i;
            fifo_rnw_q[wr_ptr_q]   <= host_if.cmd_rnw_i;
            fifo_wdata_q[wr_ptr_q] <= host_if.cmd_wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            ready_en_q    <= 1'b0;
            timer_q       <= '0;
            retry_q       <= '0;
            ctrl_addr_q   <= '0;
            ctrl_rnw_q    <= 1'b0;
            ctrl_wdata_q  <= '0;
            rsp_addr_q    <= '0;
            rsp_rdata_q   <= '0;
            rsp_status_q  <= '0;
            rsp_retries_q <= '0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            ready_en_q    <= 1'b1;
            timer_q       <= timer_d;
            retry_q       <= retry_d;
            ctrl_addr_q   <= ctrl_addr_d;
            ctrl_rnw_q    <= ctrl_rnw_d;
            ctrl_wdata_q  <= ctrl_wdata_d;
            rsp_addr_q    <= rsp_addr_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_status_q  <= rsp_status_d;
            rsp_retries_q <= rsp_retries_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d      = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        level_d       = level_q;
        timer_d       = timer_q;
        retry_d       = retry_q;
        ctrl_addr_d   = ctrl_addr_q;
        ctrl_rnw_d    = ctrl_rnw_q;
        ctrl_wdata_d  = ctrl_wdata_q;
        rsp_addr_d    = rsp_addr_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_status_d  = rsp_status_q;
        rsp_retries_d = rsp_retries_q;

        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if ((level_q != '0) && (ctrl_state_i == CTRL_IDLE)) begin
                    ctrl_addr_d  = fifo_addr_q[rd_ptr_q];
                    ctrl_rnw_d   = fifo_rnw_q[rd_ptr_q];
                    ctrl_wdata_d = fifo_wdata_q[rd_ptr_q];
                    // Loaded here so the launch cycle already counts toward the budget.
                    timer_d      = TMR_LOAD;
                    state_d      = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (timer_q != '0) timer_d = timer_q - TMR_W'(1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (timer_q != '0) timer_d = timer_q - TMR_W'(1);
                rsp_addr_d    = ctrl_addr_q;
                rsp_retries_d = sat_retries(retry_q);
                if (ctrl_error_i) begin
                    if (retry_q < RTY_MAX) begin
                        retry_d = retry_q + RTY_W'(1);
                        state_d = S_IDLE;
                    end else begin
                        rsp_status_d = ST_ERROR;
                        rsp_rdata_d  = '0;
                        state_d      = S_RESP;
                    end
                end else if (ctrl_transfer_complete_i) begin
                    rsp_status_d = ST_OK;
                    rsp_rdata_d  = ctrl_rnw_q ? ctrl_read_data_i : '0;
                    state_d      = S_RESP;
                end else if (timer_q == '0) begin
                    rsp_status_d = ST_TIMEOUT;
                    rsp_rdata_d  = '0;
                    state_d      = S_RESP;
                end
            end
            S_RESP: begin
                if (host_if.rsp_ready_i) begin
                    retry_d = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        host_if.cmd_ready_o    = cmd_ready;
        host_if.rsp_valid_o    = (state_q == S_RESP);
        host_if.rsp_addr_o     = rsp_addr_q;
        host_if.rsp_rdata_o    = rsp_rdata_q;
        host_if.rsp_status_o   = rsp_status_q;
        host_if.rsp_retries_o  = rsp_retries_q;
        ctrl_start_transfer_o  = (state_q == S_LAUNCH);
        ctrl_device_address_o  = ctrl_addr_q;
        ctrl_is_read_o         = ctrl_rnw_q;
        ctrl_write_data_o      = ctrl_wdata_q;
        fifo_level_o           = level_q;
        busy_o                 = (state_q != S_IDLE) || (level_q != '0);
    end
endmodule
